ascii2key_ps2_tx: RTL



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ascii2key.sv | 86 ++++++++
 rtl/ascii2key_ps2_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM state type and frame helper for the PS/2 transmit path
//
// Contents:
//   BREAK_PREFIX  break (key release) prefix byte
//   LSHIFT        left-shift make code used to wrap uppercase letters
//   FRAME_BITS    bits per device-to-host frame (start, 8 data, parity, stop)
//   tx_state_t    transmit FSM states
//   ps2_frame()   builds an 11-bit frame, bit 0 first on the wire
package ps2_pkg;

  localparam logic [7:0] BREAK_PREFIX  = 8'hF0;
  localparam logic [7:0] LSHIFT        = 8'h12;
  localparam int         FRAME_BITS    = 11;
  localparam int         MAX_SEQ_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT,
    ST_GAP
  } tx_state_t;

  // Frame layout LSB-first: start(0), data[0..7], odd parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ascii2key.sv
// rtl/ascii2key.sv - combinational ASCII to PS/2 Set-2 make code lookup
//
// Ports:
//   ascii_in   character to translate
//   supported  1 when the character has a mapping
//   shifted    1 when the character is an uppercase letter (needs left shift)
//   scan_code  Set-2 make code (0 when unsupported)
module ascii2key
  import ps2_pkg::*;
(
  input  logic [7:0] ascii_in,
  output logic       supported,
  output logic       shifted,
  output logic [7:0] scan_code
);

  logic       is_upper;
  logic [7:0] lower;

  // Uppercase letters fold onto the lowercase entry; the shift wrap is
  // added by the sequencer.
  assign is_upper = (ascii_in >= 8'h41) && (ascii_in <= 8'h5A);
  assign lower    = is_upper ? (ascii_in | 8'h20) : ascii_in;

  always_comb begin
    supported = 1'b1;
    scan_code = 8'h00;
    case (lower)
      8'h30: scan_code = 8'h45;  // 0
      8'h31: scan_code = 8'h16;
      8'h32: scan_code = 8'h1E;
      8'h33: scan_code = 8'h26;
      8'h34: scan_code = 8'h25;
      8'h35: scan_code = 8'h2E;
      8'h36: scan_code = 8'h36;
      8'h37: scan_code = 8'h3D;
      8'h38: scan_code = 8'h3E;
      8'h39: scan_code = 8'h46;  // 9
      8'h61: scan_code = 8'h1C;  // a
      8'h62: scan_code = 8'h32;
      8'h63: scan_code = 8'h21;
      8'h64: scan_code = 8'h23;
      8'h65: scan_code = 8'h24;
      8'h66: scan_code = 8'h2B;
      8'h67: scan_code = 8'h34;
      8'h68: scan_code = 8'h33;
      8'h69: scan_code = 8'h43;
      8'h6A: scan_code = 8'h3B;
      8'h6B: scan_code = 8'h42;
      8'h6C: scan_code = 8'h4B;
      8'h6D: scan_code = 8'h3A;
      8'h6E: scan_code = 8'h31;
      8'h6F: scan_code = 8'h44;
      8'h70: scan_code = 8'h4D;
      8'h71: scan_code = 8'h15;
      8'h72: scan_code = 8'h2D;
      8'h73: scan_code = 8'h1B;
      8'h74: scan_code = 8'h2C;
      8'h75: scan_code = 8'h3C;
      8'h76: scan_code = 8'h2A;
      8'h77: scan_code = 8'h1D;
      8'h78: scan_code = 8'h22;
      8'h79: scan_code = 8'h35;
      8'h7A: scan_code = 8'h1A;  // z
      8'h60: scan_code = 8'h0E;  // `
      8'h2D: scan_code = 8'h4E;  // -
      8'h3D: scan_code = 8'h55;  // =
      8'h5B: scan_code = 8'h54;  // [
      8'h5D: scan_code = 8'h5B;  // ]
      8'h5C: scan_code = 8'h5D;  // backslash
      8'h3B: scan_code = 8'h4C;  // ;
      8'h27: scan_code = 8'h52;  // '
      8'h2C: scan_code = 8'h41;  // ,
      8'h2E: scan_code = 8'h49;  // .
      8'h2F: scan_code = 8'h4A;  // /
      8'h20: scan_code = 8'h29;  // space
      8'h0A: scan_code = 8'h5A;  // line feed -> enter
      8'h08: scan_code = 8'h66;  // backspace
      8'h09: scan_code = 8'h0D;  // tab
      default: supported = 1'b0;
    endcase
  end

  assign shifted = is_upper && supported;

endmodule

// File: rtl/ascii2key_ps2_tx.sv
// rtl/ascii2key_ps2_tx.sv - ASCII character to PS/2 device-side make/break transmitter
//
// Ports:
//   clk, resetn    system clock, asynchronous active-low reset
//   ascii_in       character, captured when ascii_valid && ascii_ready
//   ascii_valid    character available
//   ascii_ready    accepting a character (IDLE with output drained)
//   ps2_clk_out    PS/2 clock, 1 = released
//   ps2_data_out   PS/2 data, 1 = released
//   busy           transmission in progress, from accept to end of last gap
//   unsupported    one-cycle pulse for an accepted character with no mapping
module ascii2key_ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV  = 2500,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  output logic       busy,
  output logic       unsupported
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  tx_state_t             state, state_nxt;
  logic [7:0]            char_q;
  logic [7:0]            lookup_char;
  logic                  map_supported, map_shifted;
  logic [7:0]            map_code;
  logic [47:0]           seq_load;
  logic [47:0]           seq_sr;
  logic [FRAME_BITS-1:0] frame_sr;
  logic [DIV_W-1:0]      div_cnt;
  logic                  phase;        // 0 = clock-high half, 1 = clock-low half
  logic [3:0]            bit_idx;
  logic [GAP_W-1:0]      gap_idx;
  logic [2:0]            byte_idx;
  logic [2:0]            byte_last;
  logic                  busy_q, unsup_q, clk_q, data_q;
  logic                  clk_d, data_d, unsup_d;
  logic                  accept, half_end, bit_end, last_bit, last_gap, last_byte;

  // While idle the lookup looks at the live input so busy can be decided on
  // the accepting edge; afterwards it looks at the captured character.
  assign lookup_char = (state == ST_IDLE) ? ascii_in : char_q;

  ascii2key u_map (
    .ascii_in  (lookup_char),
    .supported (map_supported),
    .shifted   (map_shifted),
    .scan_code (map_code)
  );

  // Byte 0 sits in the low octet; the sequencer shifts right one byte per frame.
  assign seq_load = map_shifted
                  ? {LSHIFT, BREAK_PREFIX, map_code, BREAK_PREFIX, map_code, LSHIFT}
                  : {24'h000000, map_code, BREAK_PREFIX, map_code};

  // The line registers lag the FSM by one cycle, so ready is held off for one
  // extra IDLE cycle (busy_q still set) until the last gap has left the pins.
  assign ascii_ready = (state == ST_IDLE) && !busy_q;
  assign accept      = ascii_valid && ascii_ready;

  assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_end   = half_end && phase;
  assign last_bit  = (bit_idx == 4'(FRAME_BITS - 1));
  assign last_gap  = (gap_idx == GAP_W'(GAP_BITS - 1));
  assign last_byte = (byte_idx == byte_last);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = map_supported ? ST_BIT : ST_IDLE;
      ST_BIT:  if (bit_end && last_bit) state_nxt = ST_GAP;
      ST_GAP:  if (bit_end && last_gap) state_nxt = last_byte ? ST_IDLE : ST_BIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic (registered below so the pins never glitch)
  always_comb begin
    clk_d   = 1'b1;
    data_d  = 1'b1;
    unsup_d = 1'b0;
    case (state)
      ST_LOAD: unsup_d = !map_supported;
      ST_BIT: begin
        clk_d  = !phase;
        data_d = frame_sr[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
      unsup_q <= 1'b0;
    end else begin
      clk_q   <= clk_d;
      data_q  <= data_d;
      unsup_q <= unsup_d;
    end
  end

  // Handshake capture and busy flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      char_q <= 8'h00;
      busy_q <= 1'b0;
    end else begin
      if (accept) begin
        char_q <= ascii_in;
        busy_q <= map_supported;
      end else if (state == ST_IDLE) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Timing counters, byte sequence and frame shift register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_idx   <= 4'd0;
      gap_idx   <= '0;
      byte_idx  <= 3'd0;
      byte_last <= 3'd0;
      seq_sr    <= '0;
      frame_sr  <= '1;
    end else begin
      case (state)
        ST_LOAD: begin
          div_cnt   <= '0;
          phase     <= 1'b0;
          bit_idx   <= 4'd0;
          gap_idx   <= '0;
          byte_idx  <= 3'd0;
          byte_last <= map_shifted ? 3'd5 : 3'd2;
          seq_sr    <= seq_load;
          frame_sr  <= ps2_frame(seq_load[7:0]);
        end
        ST_BIT, ST_GAP: begin
          if (half_end) begin
            div_cnt <= '0;
            phase   <= !phase;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
          if (state == ST_BIT && bit_end) begin
            bit_idx  <= last_bit ? 4'd0 : bit_idx + 4'd1;
            frame_sr <= {1'b1, frame_sr[FRAME_BITS-1:1]};
          end
          if (state == ST_GAP && bit_end) begin
            gap_idx <= last_gap ? '0 : gap_idx + GAP_W'(1);
            if (last_gap) begin
              // Preload the next frame so its start bit appears on the first
              // cycle of the following BIT state.
              byte_idx <= byte_idx + 3'd1;
              seq_sr   <= {8'h00, seq_sr[47:8]};
              frame_sr <= ps2_frame(seq_sr[15:8]);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ps2_clk_out  = clk_q;
  assign ps2_data_out = data_q;
  assign busy         = busy_q;
  assign unsupported  = unsup_q;

endmodule
